// File: rtl/booth_radix8_multiplier.sv
// Sequential radix-8 Booth multiplier: one Booth digit (-4..+4) per clock, signed/unsigned per operand.
// Define BOOTH_EARLY_TERM_EN to finish as soon as every remaining multiplier digit is zero.
module booth_radix8_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic [1:0]           sign_mode,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done,
  output logic                 busy
);

  localparam int NDIG = (WIDTH + 4) / 3;
  localparam int ACCW = 2*WIDTH + 4;
  localparam int BW   = 3*NDIG + 1;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, PRECOMP, CALC} state_t;

  state_t          state_q;
  logic [ACCW-1:0] acc_q, mult_q, m3_q;
  logic [BW-1:0]   b_q;
  logic [CW-1:0]   cnt_q;
  logic [ACCW-1:0] mag_d, acc_d;
  logic            neg_d, finish_d;

  // b_q[3:0] is the current Booth window; bit 0 is the overlap bit from the previous digit.
  always_comb begin
    mag_d = '0;
    neg_d = 1'b0;
    unique case (b_q[3:0])
      4'b0001, 4'b0010: mag_d = mult_q;
      4'b0011, 4'b0100: mag_d = mult_q << 1;
      4'b0101, 4'b0110: mag_d = m3_q;
      4'b0111:          mag_d = mult_q << 2;
      4'b1000:          begin mag_d = mult_q << 2; neg_d = 1'b1; end
      4'b1001, 4'b1010: begin mag_d = m3_q;        neg_d = 1'b1; end
      4'b1011, 4'b1100: begin mag_d = mult_q << 1; neg_d = 1'b1; end
      4'b1101, 4'b1110: begin mag_d = mult_q;      neg_d = 1'b1; end
      default:          mag_d = '0;
    endcase
    acc_d = acc_q + (mag_d ^ {ACCW{neg_d}}) + {{(ACCW-1){1'b0}}, neg_d};
`ifdef BOOTH_EARLY_TERM_EN
    finish_d = (cnt_q == CW'(NDIG)) || (b_q == '0) || (b_q == '1);
`else
    finish_d = (cnt_q == CW'(NDIG));
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mult_q  <= '0;
      m3_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      product <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mult_q  <= {{(ACCW-WIDTH){sign_mode[1] & multiplicand[WIDTH-1]}}, multiplicand};
            b_q     <= {{(BW-1-WIDTH){sign_mode[0] & multiplier[WIDTH-1]}}, multiplier, 1'b0};
            busy    <= 1'b1;
            state_q <= PRECOMP;
          end
        end
        PRECOMP: begin
          m3_q    <= mult_q + (mult_q << 1);
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= CALC;
        end
        CALC: begin
          if (finish_d) begin
            product <= acc_q[2*WIDTH-1:0];
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end else begin
            // Arithmetic wrap in the accumulator is harmless: the true product fits in 2*WIDTH bits.
            acc_q  <= acc_d;
            mult_q <= mult_q << 3;
            m3_q   <= m3_q << 3;
            b_q    <= {{3{b_q[BW-1]}}, b_q[BW-1:3]};
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix8_multiplier.sv
// Self-checking bench for booth_radix8_multiplier: directed corners, handshake, reset abort, random ops.
module tb_booth_radix8_multiplier;

  localparam int W   = 16;
  localparam int LAT = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  multiplicand, multiplier;
  logic [1:0]    sign_mode;
  logic [2*W-1:0] product;
  logic          done, busy;

  int n_assert = 0;
  int n_fail   = 0;

  booth_radix8_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier), .sign_mode(sign_mode),
    .product(product), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] m);
    longint ea, eb;
    ea = m[1] ? longint'($signed(a)) : longint'(a);
    eb = m[0] ? longint'($signed(b)) : longint'(b);
    return (2*W)'(ea * eb);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one operation, wait for done (bounded), check latency, busy, product and pulse width.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] m, input logic [2*W-1:0] exp);
    int lat;
    bit busy_ok;
    @(negedge clk);
    multiplicand = a; multiplier = b; sign_mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    multiplicand = W'($urandom); multiplier = W'($urandom); sign_mode = 2'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(LAT));
    chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
    chk({tag, "_prod"}, 64'(product), 64'(exp));
    $display("op %s: mode=%b a=%h b=%h product=%h latency=%0d", tag, m, a, b, product, lat);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat;
    bit seen_done;
    rst_n = 1'b0; start = 1'b0;
    multiplicand = '0; multiplier = '0; sign_mode = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_product", 64'(product), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("u_10x5",       16'd10,   16'd5,    2'b00, 32'h0000_0032);
    run_op("s_m10x5",      16'hFFF6, 16'd5,    2'b11, 32'hFFFF_FFCE);
    run_op("s_8000x8000",  16'h8000, 16'h8000, 2'b11, 32'h4000_0000);
    run_op("s_8000x7fff",  16'h8000, 16'h7FFF, 2'b11, 32'hC000_8000);
    run_op("s_7fffx7fff",  16'h7FFF, 16'h7FFF, 2'b11, 32'h3FFF_0001);
    run_op("u_ffffxffff",  16'hFFFF, 16'hFFFF, 2'b00, 32'hFFFE_0001);
    run_op("u_ffffx0",     16'hFFFF, 16'h0000, 2'b00, 32'h0000_0000);
    run_op("m10_fff6x000a", 16'hFFF6, 16'h000A, 2'b10, 32'hFFFF_FF9C);
    run_op("m01_000axfff6", 16'h000A, 16'hFFF6, 2'b01, 32'hFFFF_FF9C);

    // Start pulsed while busy must be ignored.
    @(negedge clk);
    multiplicand = 16'd10; multiplier = 16'd5; sign_mode = 2'b00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    multiplicand = 16'd1234; multiplier = 16'd777; sign_mode = 2'b11; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 2;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("ignore_lat", 64'(lat), 64'(LAT));
    chk("ignore_prod", 64'(product), 64'h32);
    $display("op ignore_busy_start: product=%h latency=%0d", product, lat);
    @(negedge clk);
    chk("ignore_no_restart", 64'(busy), 64'd0);

    // Reset during CALC aborts the operation without a done pulse.
    @(negedge clk);
    multiplicand = 16'd300; multiplier = 16'd400; sign_mode = 2'b00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_product", 64'(product), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", 64'(seen_done), 64'd0);
    $display("op reset_abort: busy=%b product=%h done_seen=%b", busy, product, seen_done);

    // Random operations, 50 per signedness mode, with occasional extreme operands.
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 50; i++) begin
        logic [W-1:0] a, b;
        a = W'($urandom);
        b = W'($urandom);
        if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'hFFFF;
        if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h0000;
        run_op($sformatf("rnd_m%0d_%0d", m, i), a, b, 2'(m), golden(a, b, 2'(m)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_radix8_multiplier.md
Name: booth_radix8_multiplier

Overview:
Sequential radix-8 (modified Booth, digit set -4..+4) multiplier. Produces the full 2*WIDTH-bit product of two WIDTH-bit operands. Each operand is independently treated as signed or unsigned. Sits as a multi-cycle arithmetic slave behind a start/done/busy handshake; one Booth digit is retired per clock.

Parameters:
WIDTH, 16, operand width in bits (>=4); product is 2*WIDTH bits.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst_n  input  1  reset, synchronous, active-low.
start  input  1  request; sampled on a rising edge only while busy=0.
multiplicand  input  WIDTH  operand A, captured when start is accepted.
multiplier  input  WIDTH  operand B, captured when start is accepted.
sign_mode  input  2  [1]=1: A signed, [0]=1: B signed (0 = unsigned); captured with the operands.
product  output  2*WIDTH  result: two's complement if either operand is signed, else unsigned.
done  output  1  one-cycle pulse: product valid.
busy  output  1  high while an operation is in progress.

Behaviour:
- Reset (rst_n=0 at a rising edge): state IDLE, product=0, done=0, busy=0, internal registers cleared. Reset mid-operation aborts it; no done pulse is produced.
- Operand extension: A_ext = A extended to WIDTH+1 bits (sign-extend if sign_mode[1], else zero-extend). B_ext = B extended to WIDTH+2 bits the same way per sign_mode[0], then sign-extended to NDIG*3 bits, where NDIG = ceil((WIDTH+2)/3) (6 for WIDTH=16). A 0 is appended below bit 0 for recoding.
- Recoding: digit i is formed from B_ext bits {3i+2, 3i+1, 3i, 3i-1}, with value -4b3 + 2b2 + b1 + b0 + ... per standard radix-8 Booth. Resulting values:
  - 0000/1111 -> 0
  - 0001/0010 -> +1
  - 0011/0100 -> +2
  - 0101/0110 -> +3
  - 0111 -> +4
  - 1000 -> -4
  - 1001/1010 -> -3
  - 1011/1100 -> -2
  - 1101/1110 -> -1
- Partial products: 3A is precomputed once per operation into a register. Each partial product is 0, ±A, ±2A, ±3A or ±4A, sign-extended to the accumulator width. Subtraction uses the one's complement plus a carry-in.
- Datapath: the accumulator is at least 2*WIDTH+4 bits, signed. Each CALC cycle does acc += digit_i * A_ext * 8^i, implemented by a multiple register shifted left 3 bits per cycle and a B shift register shifted right 3 bits per cycle. product = acc[2*WIDTH-1:0]; the exact result always fits in 2*WIDTH bits for all four modes.
- FSM:
  - IDLE: start=1 at an edge -> capture operands and mode, busy<=1, go to PRECOMP.
  - PRECOMP: one cycle; compute 3A, clear acc, digit counter=0; go to CALC.
  - CALC: one digit per cycle, NDIG cycles. On the last digit: product<=final acc, done<=1, busy<=0, go to IDLE.
- Latency: start sampled at edge k -> done=1 and product valid after edge k+2+NDIG (k+8 for WIDTH=16). done is high for exactly one cycle.
- product holds its value until the next operation completes or reset; it is not updated mid-operation.
- start while busy=1 is ignored; the operation in progress completes unchanged. start asserted in the same cycle done is high is accepted only if busy=0 (always true, since busy falls with done). Back-to-back operations with start in the cycle after done are legal.
- Operand inputs may change freely after capture.

Optional Feature:
BOOTH_EARLY_TERM_EN. When defined, CALC finishes early once all remaining unprocessed B_ext bits, including the overlap bit, are equal (all 0 or all 1), meaning every remaining digit is 0. done/busy/product then behave as at normal completion, and the minimum latency is 2 cycles (e.g. B=0). When undefined, latency is fixed at 2+NDIG cycles regardless of operands. Results are identical in both builds.

Test Plan:
- Mode 00, A=10, B=5 -> product=0x00000032; done pulse exactly 8 cycles after start (macro off); busy high throughout.
- Mode 11: -10 x 5 -> 0xFFFFFFCE; 0x8000 x 0x8000 -> 0x40000000; 0x8000 x 0x7FFF -> 0xC0008000; 0x7FFF x 0x7FFF -> 0x3FFF0001.
- Mode 00: 0xFFFF x 0xFFFF -> 0xFFFE0001; 0xFFFF x 0 -> 0.
- Mixed modes: mode 10, 0xFFF6 x 0x000A -> 0xFFFFFF9C; mode 01, 0x000A x 0xFFF6 -> 0xFFFFFF9C.
- Handshake: pulse start again while busy with different operands -> ignored, original result reported; assert rst_n=0 mid-CALC -> busy=0, product=0, no done pulse.
- Random: 200 operations, 50 per mode, each checked against a golden product computed from the extended operands.
